// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and
// the baud divider used by both receiver and transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   function automatic int cnt_serial(
      input int f_sys,
      input int f_ser
   );
      return f_sys / f_ser;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and its consumer,
// plus the receiver's error pulses.
interface uart_rx_if;

   logic       i_rx_ready;
   logic       o_rx_valid;
   logic [7:0] o_rx_data;
   logic       o_frame_err;
   logic       o_overrun;

   modport slave (
      input  i_rx_ready,
      output o_rx_valid,
      output o_rx_data,
      output o_frame_err,
      output o_overrun
   );

   modport master (
      output i_rx_ready,
      input  o_rx_valid,
      input  o_rx_data,
      input  o_frame_err,
      input  o_overrun
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, valid/ready byte
// hold, frame-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int FREQ_SYS    = 50_000_000,
   parameter int FREQ_SERIAL = 115200
) (
   input  logic      clk,
   input  logic      rstn,
   input  logic      i_rx,
   output logic      o_idle,
   uart_rx_if.slave  rx_bus
);

   localparam int CNT_SERIAL = cnt_serial(FREQ_SYS, FREQ_SERIAL);
   localparam int CNT_HALF   = CNT_SERIAL / 2;
   localparam int CW         = $clog2(CNT_SERIAL);
   localparam logic [CW-1:0] C_FULL = CW'(CNT_SERIAL - 1);
   localparam logic [CW-1:0] C_HALF = CW'(CNT_HALF - 1);

   logic          w_rx;
   logic          w_fall;
   logic          w_tick;
   logic          w_done;
   logic          w_ferr;
   logic          w_shift;
   logic          w_chg;
   state_t        r_state;
   state_t        w_next;
   logic          r_rx_d;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_valid;
   logic [7:0]    r_data;
   logic          r_ferr;
   logic          r_ovr;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .i_d  (i_rx),
      .o_q  (w_rx)
   );

   assign w_fall = r_rx_d & ~w_rx;
   assign w_tick = (r_cnt == C_FULL);
   assign w_chg  = (w_next != r_state);

   always_comb begin
      w_next  = r_state;
      w_done  = 1'b0;
      w_ferr  = 1'b0;
      w_shift = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_fall) w_next = S_START;
         end
         S_START: begin
            // a line back high at mid start bit is a glitch
            if (r_cnt == C_HALF)
               w_next = w_rx ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (w_tick) begin
               w_shift = 1'b1;
               if (r_bit == 3'd7) w_next = S_STOP;
            end
         end
         S_STOP: begin
            if (w_tick) begin
               if (w_rx) begin
                  w_done = 1'b1;
                  w_next = S_IDLE;
               end else begin
                  w_ferr = 1'b1;
                  w_next = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (w_rx) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_rx_d  <= 1'b1;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_next;
         r_rx_d  <= w_rx;
         if (w_chg || w_tick) r_cnt <= '0;
         else                 r_cnt <= r_cnt + CW'(1);
         if (w_chg)        r_bit <= '0;
         else if (w_shift) r_bit <= r_bit + 3'd1;
         if (w_shift) r_shift <= {w_rx, r_shift[7:1]};
      end
   end

   // a completing byte wins over a same-cycle accept
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_data  <= 8'h00;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= w_ferr;
         r_ovr  <= w_done & r_valid & ~rx_bus.i_rx_ready;
         if (w_done) begin
            r_valid <= 1'b1;
            r_data  <= r_shift;
         end else if (rx_bus.i_rx_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign rx_bus.o_rx_valid  = r_valid;
   assign rx_bus.o_rx_data   = r_data;
   assign rx_bus.o_frame_err = r_ferr;
   assign rx_bus.o_overrun   = r_ovr;
   assign o_idle             = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus a
// randomized back-to-back stream against a byte-level model.
module tb_uart_rx;

   localparam int BIT = 50_000_000 / 115200;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic i_rx = 1'b1;
   logic o_idle;

   uart_rx_if bus ();

   uart_rx dut (
      .clk    (clk),
      .rstn   (rstn),
      .i_rx   (i_rx),
      .o_idle (o_idle),
      .rx_bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int v_cyc  = 0;
   int f_cnt  = 0;
   int o_cnt  = 0;

   always @(negedge clk) begin
      if (bus.o_rx_valid  === 1'b1) v_cyc++;
      if (bus.o_frame_err === 1'b1) f_cnt++;
      if (bus.o_overrun   === 1'b1) o_cnt++;
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // start bit, 8 data bits LSB first, nstop stop bits of value sv
   task automatic send(
      input logic [7:0] b,
      input int         nstop,
      input logic       sv
   );
      i_rx = 1'b0;
      cyc(BIT);
      for (int i = 0; i < 8; i++) begin
         i_rx = b[i];
         cyc(BIT);
      end
      for (int i = 0; i < nstop; i++) begin
         i_rx = sv;
         cyc(BIT);
      end
   endtask

   int         v0, f0, o0, exp_ovr;
   logic       m_valid;
   logic       rdy;
   logic [7:0] rb;
   int         ns;

   initial begin
      bus.i_rx_ready = 1'b0;
      cyc(3);
      chk("rst_valid", 32'(bus.o_rx_valid),  32'd0);
      chk("rst_data",  32'(bus.o_rx_data),   32'h00);
      chk("rst_idle",  32'(o_idle),          32'd1);
      chk("rst_ferr",  32'(bus.o_frame_err), 32'd0);
      chk("rst_ovr",   32'(bus.o_overrun),   32'd0);
      rstn = 1'b1;
      cyc(20);

      // single byte, consumer always ready
      bus.i_rx_ready = 1'b1;
      v0 = v_cyc; f0 = f_cnt; o0 = o_cnt;
      send(8'hA5, 1, 1'b1);
      cyc(5);
      chk("a5_data",  32'(bus.o_rx_data), 32'hA5);
      chk("a5_vcyc",  32'(v_cyc - v0),    32'd1);
      chk("a5_ferr",  32'(f_cnt - f0),    32'd0);
      chk("a5_ovr",   32'(o_cnt - o0),    32'd0);

      // held byte until accepted
      bus.i_rx_ready = 1'b0;
      send(8'h3C, 1, 1'b1);
      chk("3c_valid", 32'(bus.o_rx_valid), 32'd1);
      chk("3c_data",  32'(bus.o_rx_data),  32'h3C);
      cyc(50);
      chk("3c_hold",  32'(bus.o_rx_valid), 32'd1);
      bus.i_rx_ready = 1'b1;
      cyc(1);
      bus.i_rx_ready = 1'b0;
      chk("3c_clear", 32'(bus.o_rx_valid), 32'd0);

      // back-to-back with no accept -> one overrun
      o0 = o_cnt;
      send(8'h11, 1, 1'b1);
      send(8'h22, 1, 1'b1);
      chk("ovr_cnt",   32'(o_cnt - o0),      32'd1);
      chk("ovr_data",  32'(bus.o_rx_data),   32'h22);
      chk("ovr_valid", 32'(bus.o_rx_valid),  32'd1);
      bus.i_rx_ready = 1'b1;
      cyc(5);

      // short low glitch is rejected
      v0 = v_cyc; f0 = f_cnt;
      i_rx = 1'b0;
      cyc(50);
      chk("gl_start", 32'(o_idle), 32'd0);
      cyc(50);
      i_rx = 1'b1;
      cyc(500);
      chk("gl_idle", 32'(o_idle),       32'd1);
      chk("gl_vcyc", 32'(v_cyc - v0),   32'd0);
      chk("gl_ferr", 32'(f_cnt - f0),   32'd0);

      // low stop bit, then a held break
      v0 = v_cyc; f0 = f_cnt;
      send(8'hFF, 1, 1'b0);
      cyc(2000);
      chk("brk_ferr", 32'(f_cnt - f0), 32'd1);
      chk("brk_hold", 32'(o_idle),     32'd0);
      chk("brk_vcyc", 32'(v_cyc - v0), 32'd0);
      i_rx = 1'b1;
      cyc(10);
      chk("brk_idle",  32'(o_idle),     32'd1);
      chk("brk_ferr2", 32'(f_cnt - f0), 32'd1);
      cyc(BIT);

      // reset in data bit 4, held until the frame has passed
      bus.i_rx_ready = 1'b0;
      fork
         send(8'h5A, 1, 1'b1);
         begin
            cyc(BIT * 5 + BIT / 2);
            rstn = 1'b0;
            cyc(20);
            chk("mrst_idle",  32'(o_idle),         32'd1);
            chk("mrst_valid", 32'(bus.o_rx_valid), 32'd0);
            cyc(BIT * 5 - 20);
            rstn = 1'b1;
         end
      join
      cyc(20);
      chk("mrst_novld", 32'(bus.o_rx_valid), 32'd0);
      chk("mrst_data",  32'(bus.o_rx_data),  32'h00);
      send(8'hC3, 1, 1'b1);
      chk("c3_data",  32'(bus.o_rx_data),  32'hC3);
      chk("c3_valid", 32'(bus.o_rx_valid), 32'd1);

      // random back-to-back stream against a byte-level model
      m_valid = 1'b1;
      exp_ovr = 0;
      o0 = o_cnt;
      for (int k = 0; k < 6; k++) begin
         rdy = 1'($urandom_range(0, 1));
         rb  = 8'($urandom);
         ns  = int'($urandom_range(1, 2));
         bus.i_rx_ready = rdy;
         if (m_valid && !rdy) exp_ovr++;
         m_valid = !rdy;
         send(rb, ns, 1'b1);
         chk($sformatf("rnd%0d_data", k),  32'(bus.o_rx_data),  32'(rb));
         chk($sformatf("rnd%0d_valid", k), 32'(bus.o_rx_valid), 32'(m_valid));
         chk($sformatf("rnd%0d_ovr", k),   32'(o_cnt - o0),     32'(exp_ovr));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FREQ_SYS, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter FREQ_SERIAL, default 115200, serial baud rate in Hz.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port i_rx_ready, input, 1 bit: consumer accepts the held byte.
REQ-007 SHALL have port o_rx_valid, output, 1 bit: a received byte is held on o_rx_data.
REQ-008 SHALL have port o_rx_data, output, 8 bits: last received byte.
REQ-009 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a new byte overwrites an unaccepted byte.
REQ-011 SHALL have port o_idle, output, 1 bit: high while the FSM is in IDLE.

Function
REQ-012 SHALL synchronise i_rx through 2 flip-flops (reset value 1) before any use; all "line" references below mean the synchronised value.
REQ-013 SHALL define CNT_SERIAL = FREQ_SYS/FREQ_SERIAL (integer division) and CNT_HALF = CNT_SERIAL/2.
REQ-014 SHALL define a bit counter of width $clog2(CNT_SERIAL) that counts 0..CNT_SERIAL-1, wraps to 0, and is cleared on every state change.
REQ-015 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-016 IDLE: a high-to-low edge on the line SHALL move the FSM to START.
REQ-017 START: at counter == CNT_HALF-1, a low line SHALL move the FSM to DATA; a high line SHALL return it to IDLE (glitch rejection, no outputs).
REQ-018 DATA: after START, each sample point SHALL be at counter == CNT_SERIAL-1, which is mid-bit.
REQ-019 DATA: the FSM SHALL sample 8 bits LSB first into a shift register, then move to STOP.
REQ-020 STOP: at the mid-bit sample, a high line SHALL load o_rx_data, set o_rx_valid and return to IDLE in the same cycle.
REQ-021 STOP: at the mid-bit sample, a low line SHALL pulse o_frame_err, leave o_rx_data and o_rx_valid unchanged, and move to BREAK.
REQ-022 BREAK: the FSM SHALL return to IDLE only after the line has been sampled high.
REQ-023 SHALL assert o_rx_valid one clk after the stop-bit sample point and hold it until a cycle in which i_rx_ready is high, then clear it on the next edge.
REQ-024 SHALL treat byte completion with o_rx_valid already high and i_rx_ready low as overrun: pulse o_overrun, overwrite o_rx_data, keep o_rx_valid high.
REQ-025 SHALL give a new byte completion precedence when it coincides with i_rx_ready high: o_rx_valid stays high with the new data, and no overrun.
REQ-026 SHALL accept back-to-back frames: a start edge arriving immediately after the stop sample is detected, with 1 or 2 stop bits accepted.
REQ-027 SHALL ignore i_rx_ready while o_rx_valid is low.

Reset
REQ-028 On rstn low, the block SHALL asynchronously force: FSM to IDLE, counters to 0, synchroniser flip-flops to 1, o_rx_valid 0, o_rx_data 8'h00, o_frame_err 0, o_overrun 0, o_idle 1.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte, and the block SHALL not report a frame after release until a fresh start edge.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum and a function computing CNT_SERIAL from FREQ_SYS and FREQ_SERIAL, shared with the transmitter.
REQ-031 The line synchroniser SHALL be a sub-module named sync_2ff; all other logic SHALL be flat in uart_rx.

Verification
REQ-032 Defaults (CNT_SERIAL=434), bench transmitter sends 8'hA5 with 1 stop bit, i_rx_ready=1 -> o_rx_valid high for 1 cycle, o_rx_data=8'hA5, no error pulses.
REQ-033 8'h3C sent with i_rx_ready=0 -> o_rx_valid held high; raising i_rx_ready for 1 cycle -> o_rx_valid low on the next edge.
REQ-034 8'h11 then 8'h22 sent back-to-back with i_rx_ready=0 -> o_overrun pulses once, o_rx_data=8'h22, o_rx_valid stays high.
REQ-035 A 100-cycle low glitch on an idle line -> FSM returns to IDLE, no o_rx_valid, no o_frame_err.
REQ-036 Frame 8'hFF with the stop bit driven low, then the line held low for 2000 cycles, then high -> o_frame_err pulses once, FSM stays in BREAK until the line is high, o_rx_valid stays low.
REQ-037 rstn pulsed low during data bit 4 of 8'h5A, then 8'hC3 sent -> no output for the first frame, then o_rx_data=8'hC3 with o_rx_valid high.
